// File: rtl/mmm_serial.sv
// Bit-serial radix-2 Montgomery multiplier: p = a*b*2^-WIDTH mod m.
// One iteration per enabled cycle, a final conditional subtraction, then a one-cycle done pulse.
module mmm_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             en,
  input  logic             rst_mmm,
  input  logic             ld_a,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] p,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int AW = WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_r_q, b_r_d;
  logic [WIDTH-1:0] m_r_q, m_r_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    i_q, i_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic             done_q, done_d;

  logic [AW-1:0]    t_sum;
  logic [AW-1:0]    u_sum;

  // State register.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDLE;
    end else if (en) begin
      state_q <= state_d;
    end
  end

  // Next-state logic: soft clear beats a start, and a start aborts any operation in flight.
  always_comb begin
    state_d = state_q;
    if (!rst_mmm) begin
      state_d = IDLE;
    end else if (ld_a) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN:     if (i_q == CW'(WIDTH - 1)) state_d = FIX;
        FIX:     state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  // Output logic: purely from registers, so no input-to-output combinational path.
  always_comb begin
    busy = (state_q == RUN) || (state_q == FIX);
    p    = p_q;
    done = done_q;
  end

  // One Montgomery step; acc < 2m keeps both sums below 4m, which fits in WIDTH+2 bits.
  always_comb begin
    t_sum = acc_q + (a_sh_q[0] ? {2'b00, b_r_q} : '0);
    u_sum = t_sum + (t_sum[0] ? {2'b00, m_r_q} : '0);
  end

  always_comb begin
    // NOTE: every variable gets a default before the branches so no path leaves it unassigned, which would infer a latch.
    a_sh_d = a_sh_q;
    b_r_d  = b_r_q;
    m_r_d  = m_r_q;
    acc_d  = acc_q;
    i_d    = i_q;
    p_d    = p_q;
    done_d = 1'b0;
    if (!rst_mmm) begin
      a_sh_d = '0;
      b_r_d  = '0;
      m_r_d  = '0;
      acc_d  = '0;
      i_d    = '0;
      p_d    = '0;
    end else if (ld_a) begin
      a_sh_d = a;
      b_r_d  = b;
      m_r_d  = m;
      acc_d  = '0;
      i_d    = '0;
    end else begin
      case (state_q)
        RUN: begin
          acc_d  = u_sum >> 1;
          a_sh_d = a_sh_q >> 1;
          i_d    = i_q + CW'(1);
        end
        FIX: begin
          p_d    = (acc_q >= {2'b00, m_r_q}) ? WIDTH'(acc_q - {2'b00, m_r_q})
                                             : acc_q[WIDTH-1:0];
          done_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      a_sh_q <= '0;
      b_r_q  <= '0;
      m_r_q  <= '0;
      acc_q  <= '0;
      i_q    <= '0;
      p_q    <= '0;
      done_q <= 1'b0;
    end else if (en) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
      a_sh_q <= a_sh_d;
      b_r_q  <= b_r_d;
      m_r_q  <= m_r_d;
      acc_q  <= acc_d;
      i_q    <= i_d;
      p_q    <= p_d;
      done_q <= done_d;
    end
  end

endmodule

// File: tb/tb_mmm_serial.sv
// Scoreboard bench for mmm_serial (WIDTH=8, m=239): stimulus pushes hand-computed products,
// a negedge monitor pops one per done pulse and compares p.
module tb_mmm_serial;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rstb;
  logic             en;
  logic             rst_mmm;
  logic             ld_a;
  logic [WIDTH-1:0] a, b, m;
  logic [WIDTH-1:0] p;
  logic             busy;
  logic             done;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;
  logic done_prev = 1'b0;
  logic [WIDTH-1:0] exp_q[$];

  mmm_serial #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rstb    (rstb),
    .en      (en),
    .rst_mmm (rst_mmm),
    .ld_a    (ld_a),
    .a       (a),
    .b       (b),
    .m       (m),
    .p       (p),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // Monitor: one scoreboard pop per rising edge of done (a stretched done counts once).
  always @(negedge clk) begin
    if (rstb && done && !done_prev) begin
      pulses++;
      check("done_has_expectation", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("p_result", 32'(p), 32'(exp_q.pop_front()));
    end
    done_prev = done;
  end

  // Issue a one-cycle ld_a; returns 1ns after the sampling edge.
  task automatic start(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] ev);
    @(posedge clk); #1;
    a = av; b = bv; m = 8'd239; ld_a = 1'b1;
    exp_q.push_back(ev);
    @(posedge clk); #1;
    ld_a = 1'b0;
  endtask

  // c = negedges after the start edge until done is seen; bc = busy cycles in that window.
  task automatic measure(output int c, output int bc);
    c = 0; bc = 0;
    @(negedge clk);
    while (!done && c < 40) begin
      if (busy) bc++;
      @(negedge clk);
      c++;
    end
  endtask

  typedef struct { logic [7:0] av; logic [7:0] bv; logic [7:0] ev; } vec_t;
  vec_t vecs[$];

  initial begin
    int c, bc, p0;
    rstb = 1'b0; en = 1'b1; rst_mmm = 1'b1; ld_a = 1'b0;
    a = '0; b = '0; m = 8'd239;
    repeat (3) @(negedge clk);
    rstb = 1'b1;

    // 1: idle after reset
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("idle_outputs", 32'({p, busy, done}), 32'd0);
    end

    // 2: basic latency and busy window
    start(8'd5, 8'd17, 8'd5);
    measure(c, bc);
    check("latency_basic", 32'(c), 32'd9);
    check("busy_cycles", 32'(bc), 32'd9);
    check("busy_low_at_done", 32'(busy), 32'd0);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("p_holds", 32'(p), 32'd5);

    // 3: directed vectors (R mod 239 = 17, R^-1 mod 239 = 225)
    vecs = '{'{8'd238, 8'd238, 8'd225}, '{8'd1, 8'd1, 8'd225}, '{8'd0, 8'd100, 8'd0},
             '{8'd17, 8'd17, 8'd17}, '{8'd17, 8'd100, 8'd100}, '{8'd238, 8'd17, 8'd238}};
    foreach (vecs[j]) begin
      start(vecs[j].av, vecs[j].bv, vecs[j].ev);
      measure(c, bc);
      check("latency_vec", 32'(c), 32'd9);
    end

    // 4: enable stall mid-RUN, then done stretch
    start(8'd5, 8'd17, 8'd5);
    c = 0;
    @(negedge clk);
    while (!done && c < 40) begin
      if (c == 3) en = 1'b0;
      if (c == 7) en = 1'b1;
      @(negedge clk);
      c++;
    end
    check("latency_stalled", 32'(c), 32'd13);
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("done_stretch", 32'(done), 32'd1);
    end
    en = 1'b1;
    @(negedge clk);
    check("done_after_stretch", 32'(done), 32'd0);

    // 5: restart while busy
    start(8'd5, 8'd17, 8'd5);
    repeat (4) @(negedge clk);
    p0 = pulses;
    void'(exp_q.pop_back());
    start(8'd238, 8'd238, 8'd225);
    measure(c, bc);
    check("latency_restart", 32'(c), 32'd9);
    repeat (12) @(negedge clk);
    check("single_done_restart", 32'(pulses - p0), 32'd1);

    // 6a: synchronous soft clear mid-RUN (p is 225 beforehand)
    start(8'd17, 8'd17, 8'd17);
    void'(exp_q.pop_back());
    repeat (4) @(negedge clk);
    rst_mmm = 1'b0;
    p0 = pulses;
    @(negedge clk);
    check("softclr_busy", 32'(busy), 32'd0);
    check("softclr_p", 32'(p), 32'd0);
    check("softclr_done", 32'(done), 32'd0);
    rst_mmm = 1'b1;
    repeat (12) @(negedge clk);
    check("softclr_no_done", 32'(pulses - p0), 32'd0);

    // 6b: asynchronous reset mid-RUN (p is 17 beforehand)
    start(8'd17, 8'd17, 8'd17);
    measure(c, bc);
    check("latency_pre_async", 32'(c), 32'd9);
    start(8'd238, 8'd238, 8'd225);
    void'(exp_q.pop_back());
    repeat (4) @(negedge clk);
    p0 = pulses;
    #2 rstb = 1'b0;
    #1;
    check("async_busy", 32'(busy), 32'd0);
    check("async_p", 32'(p), 32'd0);
    check("async_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    repeat (12) @(negedge clk);
    check("async_no_done", 32'(pulses - p0), 32'd0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mmm_serial.md
Name: mmm_serial

Overview:
- Bit-serial radix-2 Montgomery modular multiplier.
- Forms the multiply stage of the RSA modular-exponentiation datapath and is driven by the exponentiation control FSM: its rst_mmm and ld_a outputs feed this block directly.
- Computes p = a*b*2^-WIDTH mod m in WIDTH+1 enabled cycles.
- Asserts a one-cycle done pulse with the result, so the controller can capture p with ld_r inside its 12-cycle multiply slot.

Parameters:
WIDTH, 8, operand/modulus width in bits; also the number of Montgomery iterations (R = 2^WIDTH).

Ports:
clk  input  1  system clock, rising-edge.
rstb  input  1  asynchronous active-low reset.
en  input  1  global clock enable; when low, all state holds.
rst_mmm  input  1  synchronous active-low soft clear from the controller.
ld_a  input  1  load operands and start a multiplication (sampled when en=1).
a  input  WIDTH  multiplier operand; requirement a < m.
b  input  WIDTH  multiplicand operand; requirement b < m.
m  input  WIDTH  modulus; requirement: odd, m > 1.
p  output  WIDTH  Montgomery product; valid from the done cycle until the next start.
busy  output  1  high while a multiplication is in progress.
done  output  1  one-cycle pulse; p is valid.

Behaviour:
- Reset (rstb low, async): state=IDLE; p=0; busy=0; done=0; internal accumulator, shift register and counters all 0.
- rst_mmm low with en=1 at a clock edge: same clear as reset, synchronous. It takes priority over ld_a.
- en=0: no register changes, including the done pulse, which stretches while en is low.
- Internal registers:
  - a_sh: WIDTH bits, shifts right each iteration.
  - b_r, m_r: WIDTH bits, captured at start.
  - acc: WIDTH+2 bits.
  - i: iteration counter, $clog2(WIDTH+1) bits.
- States:
  - IDLE: busy=0. On ld_a=1: capture a_sh=a, b_r=b, m_r=m; clear acc=0 and i=0; go to RUN. done drops to 0.
  - RUN: busy=1. Each cycle:
    - t = acc + (a_sh[0] ? b_r : 0)
    - q = t[0]
    - acc <= (t + (q ? m_r : 0)) >> 1, all in WIDTH+2 bits with no overflow
    - a_sh <= a_sh >> 1; i <= i+1
    - After the WIDTH-th iteration (i == WIDTH-1), go to FIX.
  - FIX: busy=1. If acc >= m_r then p <= acc - m_r, else p <= acc (low WIDTH bits). Assert done=1 next cycle; go to IDLE.
- Latency: ld_a sampled at edge N; the RUN iterations occupy edges N+1..N+WIDTH; FIX at edge N+WIDTH+1; done=1 and p valid in the cycle after edge N+WIDTH+1. For WIDTH=8 that is 9 enabled cycles, which fits before the controller's ld_r at slot offset 11.
- done is high for exactly one enabled cycle, then returns to 0. p holds until the next FIX.
- ld_a while busy: abort the current operation and restart with the new operands (same as from IDLE). No done is produced for the aborted operation.
- ld_a in the same cycle as done: accepted as a new start; done still pulses for the completed result.
- Range: acc < 2m holds throughout, so one conditional subtraction guarantees p < m for legal inputs.
- Illegal inputs (even m, a or b >= m): the output is unspecified but no X propagation is allowed; the FSM must still return to IDLE after WIDTH+1 cycles.
- All arithmetic is unsigned. No combinational path from inputs to outputs.

Test Plan:
1. Reset, then rstb high, en=1, no ld_a -> p=0x00, busy=0, done=0 held for 20 cycles.
2. WIDTH=8, m=239, a=5, b=17 (R mod m) with a one-cycle ld_a -> done pulses exactly 9 cycles later with p=5; busy is high for 9 cycles.
3. m=239: a=238, b=238 -> p=225. Then a=1, b=1 -> p=225. Then a=0, b=100 -> p=0. Then a=17, b=17 -> p=17.
4. Start a=5, b=17, m=239; drop en for 4 cycles mid-RUN -> done is delayed by exactly 4 cycles and p=5; done stays high while en is low in the done cycle.
5. Start a=5, b=17; at cycle 4 pulse ld_a with a=238, b=238 -> a single done at 9 cycles after the second ld_a, with p=225.
6. Mid-RUN, pulse rst_mmm low -> next cycle busy=0, p=0, and no done. Separately, assert rstb low asynchronously mid-RUN -> immediate clear, with the same values.
